// File: rtl/disp_scan_reader.sv
// rtl/disp_scan_reader.sv - raster scanner that reads a cell-grid RAM and drives VGA timing
module disp_scan_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PIX_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL_W     = 20,
    parameter int CELL_H     = 15,
    parameter int GRID_COLS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] disp_addr,
    input  logic [DATA_WIDTH-1:0] disp_color,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int CXW     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CYW     = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    logic [DW-1:0]         r_div;
    logic [HW-1:0]         r_h;
    logic [VW-1:0]         r_v;
    logic [CXW-1:0]        r_cx;
    logic [CYW-1:0]        r_cy;
    logic [ADDR_WIDTH-1:0] r_col;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_act0;
    logic                  r_hs0;
    logic                  r_vs0;
    logic [11:0]           r_rgb;
    logic                  r_hs;
    logic                  r_vs;
    logic                  r_frame_start;

    logic                  w_tick;
    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_h_act;
    logic                  w_v_act;
    logic                  w_active;
    logic                  w_hs;
    logic                  w_vs;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_unused_bits;

    assign w_tick   = en && (r_div == DW'(PIX_DIV - 1));
    assign w_h_last = (r_h == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v == VW'(V_TOTAL - 1));
    assign w_h_act  = (r_h < HW'(H_ACTIVE));
    assign w_v_act  = (r_v < VW'(V_ACTIVE));
    assign w_active = w_h_act && w_v_act;
    assign w_hs     = !((r_h >= HW'(H_ACTIVE + H_FP)) && (r_h < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vs     = !((r_v >= VW'(V_ACTIVE + V_FP)) && (r_v < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign w_addr   = ADDR_WIDTH'(r_row * GRID_COLS) + r_col;
    assign w_unused_bits = ^disp_color[DATA_WIDTH-1:12];

    // Stage1 consumes what stage0 issued on the previous tick, so colour and syncs stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_cx          <= '0;
            r_cy          <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_addr        <= '0;
            r_act0        <= 1'b0;
            r_hs0         <= 1'b1;
            r_vs0         <= 1'b1;
            r_rgb         <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (!en) begin
                r_rgb <= '0;
                r_hs  <= 1'b1;
                r_vs  <= 1'b1;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_rgb         <= r_act0 ? disp_color[11:0] : 12'h000;
                    r_hs          <= r_hs0;
                    r_vs          <= r_vs0;
                    r_act0        <= w_active;
                    r_hs0         <= w_hs;
                    r_vs0         <= w_vs;
                    r_frame_start <= (r_h == '0) && (r_v == '0);
                    if (w_active) begin
                        r_addr <= w_addr;
                    end
                    if (w_h_last) begin
                        r_h   <= '0;
                        r_cx  <= '0;
                        r_col <= '0;
                        if (w_v_last) begin
                            r_v   <= '0;
                            r_cy  <= '0;
                            r_row <= '0;
                        end else begin
                            r_v <= r_v + 1'b1;
                            if (w_v_act) begin
                                if (r_cy == CYW'(CELL_H - 1)) begin
                                    r_cy  <= '0;
                                    r_row <= r_row + 1'b1;
                                end else begin
                                    r_cy <= r_cy + 1'b1;
                                end
                            end
                        end
                    end else begin
                        r_h <= r_h + 1'b1;
                        if (w_h_act) begin
                            if (r_cx == CXW'(CELL_W - 1)) begin
                                r_cx  <= '0;
                                r_col <= r_col + 1'b1;
                            end else begin
                                r_cx <= r_cx + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign disp_addr   = r_addr;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_disp_scan_reader.sv
// tb/tb_disp_scan_reader.sv - randomized self-checking bench for disp_scan_reader
module tb_disp_scan_reader;

    localparam int PD = 2;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 96, VF = 2, VS = 2, VB = 3;
    localparam int CW = 2, CH = 3, GC = 32;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [9:0]  disp_addr;
    logic [31:0] disp_color;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_start;

    logic [31:0] ram [0:1023];
    assign disp_color = ram[disp_addr];

    disp_scan_reader #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .PIX_DIV(PD),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_W(CW), .CELL_H(CH), .GRID_COLS(GC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .disp_addr(disp_addr), .disp_color(disp_color),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the Nth pixel tick issues raster position N (mod frame) and shows position N-1.
    int unsigned ecnt = 0;
    int unsigned tcnt = 0;
    int          p, x, y;
    logic [11:0] exp_rgb  = 12'h000;
    logic        exp_hs   = 1'b1;
    logic        exp_vs   = 1'b1;
    logic        exp_fs   = 1'b0;
    logic [9:0]  exp_addr = 10'd0;
    int          n_fs_dut = 0;
    int          n_fs_exp = 0;
    bit          chk_on   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt = 0; tcnt = 0;
            exp_rgb = 12'h000; exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0; exp_addr = 10'd0;
        end else begin
            exp_fs = 1'b0;
            if (!en) begin
                exp_rgb = 12'h000; exp_hs = 1'b1; exp_vs = 1'b1;
            end else begin
                ecnt++;
                if (ecnt % PD == 0) begin
                    tcnt++;
                    p = int'((tcnt - 1) % FRAME);
                    x = p % HT; y = p / HT;
                    if (x < HA && y < VA) exp_addr = 10'((y / CH) * GC + x / CW);
                    if (p == 0) begin
                        exp_fs = 1'b1;
                        n_fs_exp++;
                    end
                    if (tcnt >= 2) begin
                        p = int'((tcnt - 2) % FRAME);
                        x = p % HT; y = p / HT;
                        exp_rgb = (x < HA && y < VA) ? ram[(y / CH) * GC + x / CW][11:0] : 12'h000;
                        exp_hs  = !(x >= HA + HF && x < HA + HF + HS);
                        exp_vs  = !(y >= VA + VF && y < VA + VF + VS);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rgb",   {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp_rgb});
            chk("hsync", {31'd0, hsync}, {31'd0, exp_hs});
            chk("vsync", {31'd0, vsync}, {31'd0, exp_vs});
            chk("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
            chk("addr",  {22'd0, disp_addr}, {22'd0, exp_addr});
            if (frame_start) n_fs_dut++;
        end
    end

    task automatic run(input int cycles, input bit rand_en);
        int off = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                if (off > 0) begin
                    off--;
                    en = (off == 0);
                end else if ($urandom_range(0, 399) == 0) begin
                    off = $urandom_range(1, 60);
                    en = 1'b0;
                end
            end
        end
        en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        ram[0]    = 32'hABCD_0F00;
        ram[1]    = 32'h5555_00FF;
        ram[GC]   = 32'h9999_00F0;
        ram[1023] = 32'h1234_5FFF;

        @(posedge clk);
        chk_on = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;

        run(3000, 1'b0);
        run(20000, 1'b1);

        en = 1'b0;
        run(50, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        run(4000, 1'b0);

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        chk("rst_sync", {30'd0, hsync, vsync}, 32'd3);
        chk("rst_addr", {22'd0, disp_addr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(35000, 1'b1);
        run(2000, 1'b0);

        chk("fs_count", n_fs_dut, n_fs_exp);
        chk("frames_seen", {31'd0, n_fs_dut >= 3}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
